beam_steer_tx: RTL and testbench

BEAM_STEER_TX -- requirements
Module: beam_steer_tx

---
 rtl/beam_steer_tx.sv | 137 +++++++++++++
 tb/tb_beam_steer_tx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/beam_steer_tx.sv
// rtl/beam_steer_tx.sv - Two-channel transmit beam steering by one-hot selected inter-channel delay.
// Optional BEAM_STEER_MUTE_EN: mute both channels while the delay line refills after a steer change.
module beam_steer_tx #(
  parameter int DATA_WIDTH  = 16,
  parameter int DELAY_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  input  logic [7:0]            led_pattern_in,
  input  logic                  steer_load,
  output logic [DATA_WIDTH-1:0] left_data_out,
  output logic [DATA_WIDTH-1:0] right_data_out,
  output logic                  out_valid,
  output logic                  steer_err,
  output logic [1:0]            steer_state
);
  localparam int PTR_W = $clog2(DELAY_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_t;

  state_t           state;
  logic [4:0]       lag_mag_q;
  logic             right_lags_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [5:0]       fill_cnt;

  logic [DATA_WIDTH-1:0] left_buf  [DELAY_DEPTH];
  logic [DATA_WIDTH-1:0] right_buf [DELAY_DEPTH];

  logic                  code_onehot;
  logic [4:0]            code_mag;
  logic                  code_right;
  logic                  load_ok;
  state_t                eff_state;
  logic [4:0]            eff_mag;
  logic                  eff_right;
  logic [5:0]            eff_cnt;
  logic [5:0]            cnt_inc;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_WIDTH-1:0] left_tap;
  logic [DATA_WIDTH-1:0] right_tap;
  logic [DATA_WIDTH-1:0] left_next;
  logic [DATA_WIDTH-1:0] right_next;

  // Steering code to lag magnitude; code_right set when the right channel is the lagging one.
  always_comb begin
    code_onehot = 1'b1;
    code_mag    = 5'd0;
    code_right  = 1'b0;
    case (led_pattern_in)
      8'h01: code_mag = 5'd29;
      8'h02: code_mag = 5'd24;
      8'h04: code_mag = 5'd15;
      8'h08: code_mag = 5'd5;
      8'h10: begin code_mag = 5'd5;  code_right = 1'b1; end
      8'h20: begin code_mag = 5'd15; code_right = 1'b1; end
      8'h40: begin code_mag = 5'd23; code_right = 1'b1; end
      8'h80: begin code_mag = 5'd28; code_right = 1'b1; end
      default: code_onehot = 1'b0;
    endcase
  end

  // A valid load takes effect before a coincident sample, which becomes fill sample 0.
  always_comb begin
    load_ok   = steer_load && code_onehot;
    eff_state = load_ok ? FILL : state;
    eff_mag   = load_ok ? code_mag : lag_mag_q;
    eff_right = load_ok ? code_right : right_lags_q;
    eff_cnt   = load_ok ? 6'd0 : fill_cnt;
    cnt_inc   = (eff_cnt == 6'd63) ? eff_cnt : eff_cnt + 6'd1;
    rd_ptr    = wr_ptr - PTR_W'(eff_mag);
    left_tap  = left_buf[rd_ptr];
    right_tap = right_buf[rd_ptr];
  end

  always_comb begin
    left_next  = sample_in;
    right_next = sample_in;
    if (eff_state == FILL) begin
`ifdef BEAM_STEER_MUTE_EN
      left_next  = '0;
      right_next = '0;
`else
      if (eff_right) right_next = '0;
      else           left_next  = '0;
`endif
    end else if (eff_state == RUN) begin
      if (eff_right) right_next = right_tap;
      else           left_next  = left_tap;
    end
  end

  // Buffers are never cleared: FILL gating keeps stale entries off the outputs.
  always_ff @(posedge clk) begin
    if (sample_valid) begin
      left_buf[wr_ptr]  <= sample_in;
      right_buf[wr_ptr] <= sample_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      lag_mag_q      <= 5'd0;
      right_lags_q   <= 1'b0;
      wr_ptr         <= '0;
      fill_cnt       <= 6'd0;
      out_valid      <= 1'b0;
      steer_err      <= 1'b0;
      left_data_out  <= '0;
      right_data_out <= '0;
    end else begin
      out_valid <= sample_valid;
      steer_err <= steer_load && !code_onehot;
      if (load_ok) begin
        state        <= FILL;
        lag_mag_q    <= code_mag;
        right_lags_q <= code_right;
        fill_cnt     <= 6'd0;
      end
      if (sample_valid) begin
        left_data_out  <= left_next;
        right_data_out <= right_next;
        wr_ptr         <= wr_ptr + PTR_W'(1);
        if (eff_state == FILL) begin
          fill_cnt <= cnt_inc;
          if (cnt_inc == {1'b0, eff_mag}) state <= RUN;
        end
      end
    end
  end

  assign steer_state = state;

endmodule

// File: tb/tb_beam_steer_tx.sv
// tb/tb_beam_steer_tx.sv - Randomized scoreboard bench for beam_steer_tx against a sample-history model.
module tb_beam_steer_tx;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic [7:0]  led_pattern_in;
  logic        steer_load;
  logic [15:0] left_data_out;
  logic [15:0] right_data_out;
  logic        out_valid;
  logic        steer_err;
  logic [1:0]  steer_state;

  always #5 clk = ~clk;

  beam_steer_tx dut (
    .clk            (clk),
    .reset          (reset),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .led_pattern_in (led_pattern_in),
    .steer_load     (steer_load),
    .left_data_out  (left_data_out),
    .right_data_out (right_data_out),
    .out_valid      (out_valid),
    .steer_err      (steer_err),
    .steer_state    (steer_state)
  );

  typedef struct {
    logic        v;
    logic [15:0] l;
    logic [15:0] r;
    logic        e;
    logic [1:0]  st;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          dtab[8] = '{-29, -24, -15, -5, 5, 15, 23, 28};

  bit          m_loaded;
  int          m_mag;
  bit          m_right;
  int          m_since;
  logic [15:0] m_l;
  logic [15:0] m_r;
  logic [15:0] hist[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus, driven at negedge; the model's view of the next output is queued.
  task automatic cycle(input bit rst, input bit v, input logic [15:0] s, input bit ld,
                       input logic [7:0] code);
    exp_t        e;
    int          d = 0;
    logic [15:0] lag;
    @(negedge clk);
    reset = rst; sample_valid = v; sample_in = s; steer_load = ld; led_pattern_in = code;
    e.v = 1'b0;
    e.e = 1'b0;
    if (!rst) begin
      m_loaded = 0; m_mag = 0; m_right = 0; m_since = 0;
      m_l = '0; m_r = '0;
      hist.delete();
    end else begin
      e.v = v;
      if (ld) begin
        if ($countones(code) != 1) e.e = 1'b1;
        else begin
          for (int i = 0; i < 8; i++) if (code[i]) d = dtab[i];
          m_right = (d > 0); m_mag = (d > 0) ? d : -d;
          m_loaded = 1; m_since = 0;
        end
      end
      if (v) begin
        m_l = s; m_r = s;
        if (m_loaded) begin
          lag = (m_since < m_mag) ? 16'h0 : hist[hist.size() - m_mag];
          if (m_right) m_r = lag;
          else         m_l = lag;
`ifdef BEAM_STEER_MUTE_EN
          if (m_since < m_mag) begin m_l = '0; m_r = '0; end
`endif
        end
        m_since++;
        hist.push_back(s);
        if (hist.size() > 64) void'(hist.pop_front());
      end
    end
    e.l  = m_l;
    e.r  = m_r;
    e.st = !m_loaded ? 2'd0 : (m_since >= m_mag ? 2'd2 : 2'd1);
    sb_q.push_back(e);
  endtask

  task automatic ramp(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) cycle(1, 0, 16'($urandom), 0, 8'h00);
      cycle(1, 1, 16'(first + i), 0, 8'h00);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check("out_valid",   {31'b0, out_valid},  {31'b0, mon_e.v});
        check("steer_err",   {31'b0, steer_err},  {31'b0, mon_e.e});
        check("steer_state", {30'b0, steer_state}, {30'b0, mon_e.st});
        check("left_data",   {16'b0, left_data_out},  {16'b0, mon_e.l});
        check("right_data",  {16'b0, right_data_out}, {16'b0, mon_e.r});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; sample_valid = 1'b0; sample_in = '0; steer_load = 1'b0; led_pattern_in = '0;
    repeat (3) cycle(0, 0, 16'h0, 0, 8'h00);
    cycle(1, 0, 16'h0, 0, 8'h00);
    cycle(1, 1, 16'd1, 0, 8'h00);
    cycle(1, 1, 16'd2, 0, 8'h00);
    cycle(1, 1, 16'd3, 0, 8'h00);
    cycle(1, 0, 16'h5555, 0, 8'h00);

    cycle(1, 0, 16'h0, 1, 8'h10);
    ramp(40, 1);
    cycle(1, 1, 16'd41, 1, 8'h03);
    cycle(1, 0, 16'h0, 1, 8'h00);
    ramp(6, 42);

    cycle(1, 0, 16'h0, 1, 8'h01);
    ramp(100, 1);

    cycle(1, 1, 16'd500, 1, 8'h80);
    ramp(40, 501);

    cycle(1, 0, 16'h0, 1, 8'h04);
    ramp(7, 600);
    cycle(1, 1, 16'd700, 1, 8'h20);
    ramp(20, 701);

    cycle(1, 0, 16'h0, 1, 8'h40);
    ramp(10, 800);
    cycle(0, 1, 16'd810, 0, 8'h00);
    #1;
    check("rst_async_valid", {31'b0, out_valid}, 32'd0);
    check("rst_async_state", {30'b0, steer_state}, 32'd0);
    check("rst_async_left",  {16'b0, left_data_out}, 32'd0);
    cycle(0, 1, 16'd811, 0, 8'h00);
    ramp(5, 900);

    for (int i = 0; i < 400; i++) begin
      logic [7:0] code;
      bit         ld;
      ld   = ($urandom_range(0, 19) == 0);
      code = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
      cycle(1, $urandom_range(0, 3) != 0, 16'($urandom), ld, code);
    end

    repeat (3) cycle(1, 0, 16'h0, 0, 8'h00);
    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
